rect_fill: RTL and testbench
============================

# rect_fill

- Rectangle fill engine directly upstream of the framebuffer dual-port RAM.
- Accepts one rectangle command at a time (origin, size, colour) over a valid/ready handshake.
- Drives the RAM write port with one pixel per clock, row-major.
- Is the primitive used for screen clears and solid-shape drawing.

## Interface
- DATA_WIDTH, 8, pixel width in bits; matches the framebuffer data width.
- SCREEN_W, 160, framebuffer width in pixels.
- SCREEN_H, 120, framebuffer height in pixels.
- ADDR_BITS, $clog2(SCREEN_W*SCREEN_H), framebuffer address width.
- X_BITS, $clog2(SCREEN_W), width of x coordinate.
- Y_BITS, $clog2(SCREEN_H), width of y coordinate.
- Clocking and reset: one clock `wr_clk`; reset `rst` is synchronous and active-high.

Ports:
- wr_clk  in  1  sole clock; the same clock as the framebuffer write port.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  X_BITS  left column.
- cmd_y  in  Y_BITS  top row.
- cmd_w  in  X_BITS+1  width in pixels.
- cmd_h  in  Y_BITS+1  height in pixels.
- cmd_color  in  DATA_WIDTH  fill value.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse when a command completes.
- wr_en  out  1  to RAM wr_en.
- wr_addr  out  ADDR_BITS  to RAM wr_addr.
- wr_in  out  DATA_WIDTH  to RAM wr_in.

## Operation
- FSM states:
  - IDLE: cmd_ready=1 unless rst.
  - FILL: writing pixels.
- Accept condition: cmd_valid && cmd_ready at a wr_clk edge. All cmd_* fields are latched on that edge; later changes on the inputs are ignored.
- Addressing: address = y*SCREEN_W + x, truncated to ADDR_BITS.
  - The row base is computed once at accept.
  - The address increments by 1 within a row.
  - At row end, the row base advances by SCREEN_W.
  - No per-pixel multiply.
- Counters:
  - Column counter runs 0..w_eff-1; row counter runs 0..h_eff-1.
  - The last pixel is (w_eff-1, h_eff-1).
  - Row wrap produces no gap cycle.
- Empty command: if w_eff==0 or h_eff==0, no writes occur; the command completes immediately.
- Write data: wr_in holds the latched colour for the entire command.
- Outputs: all outputs except cmd_ready are registered. cmd_ready = (state==IDLE) && !rst.
- busy = (state==FILL).

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_in=0, done=0, busy=0, state=IDLE. cmd_ready=0 while rst is high.
- Accept edge E0, cycle after E0: wr_en=1, wr_addr = first pixel, busy=1.
- Throughput: one pixel per edge, giving N = w_eff*h_eff consecutive wr_en cycles.
- Completion, after edge E_N: wr_en=0, busy=0, done=1, cmd_ready=1.
  - done clears on the next edge unless another empty command is accepted on that edge.
- Back-to-back commands: a new command may be accepted on the edge that ends the done cycle. The minimum gap between write bursts is 1 cycle.
- Empty command timing: after E0, wr_en=0, done=1, cmd_ready=1.
- Reset mid-fill:
  - The FSM returns to IDLE.
  - wr_en falls on the reset edge.
  - No done pulse is produced.
  - Pixels already written are not restored.
- Arithmetic: width/height comparisons use X_BITS+1 / Y_BITS+1 bits; no overflow is possible.

## Configuration
- Macro: RECT_FILL_CLIP_EN.
- Defined:
  - w_eff = min(cmd_w, SCREEN_W-cmd_x).
  - h_eff = min(cmd_h, SCREEN_H-cmd_y).
  - If cmd_x>=SCREEN_W or cmd_y>=SCREEN_H, the command is treated as empty.
  - No write ever leaves the visible rectangle.
- Undefined:
  - w_eff=cmd_w and h_eff=cmd_h; no clipping logic is present.
  - Out-of-bounds pixels wrap into the next row or the truncated address space, per the addressing rule.
  - Callers keep commands in bounds.

## Test plan
- Reset: hold rst for 2 cycles -> wr_en=0, wr_addr=0, done=0, busy=0 throughout. cmd_ready=1 on the first cycle after rst falls.
- Basic fill: x=2, y=3, w=3, h=2, color=0xA5 -> 6 consecutive wr_en cycles at addresses 482, 483, 484, 642, 643, 644 with wr_in=0xA5. Then done=1 for 1 cycle.
- Empty: w=0, h=5 -> no wr_en. done=1 in the cycle after accept.
- Clip (RECT_FILL_CLIP_EN defined):
  - x=158, y=119, w=4, h=4 -> writes only 19198 and 19199.
  - x=160 -> no writes, done pulse.
- Back-to-back: cmd_valid held with a full-screen clear followed by a 1x1 at (0,0):
  - 19200 writes, done, then 1 write to address 0.
  - Exactly 1 idle cycle between the two bursts.
- Reset mid-fill: assert rst after the 3rd write of a 4x4 command -> wr_en=0 from the reset edge, no done. The next command executes normally.

Source files
------------

// File: rtl/rect_fill.sv
// Rectangle fill engine: one accepted command becomes a row-major burst of
// framebuffer writes, one pixel per clock. Define RECT_FILL_CLIP_EN to clip to the screen.
module rect_fill #(
  parameter int DATA_WIDTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int ADDR_BITS  = $clog2(SCREEN_W*SCREEN_H),
  parameter int X_BITS     = $clog2(SCREEN_W),
  parameter int Y_BITS     = $clog2(SCREEN_H)
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_BITS-1:0]     cmd_x,
  input  logic [Y_BITS-1:0]     cmd_y,
  input  logic [X_BITS:0]       cmd_w,
  input  logic [Y_BITS:0]       cmd_h,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0] wr_in
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(SCREEN_W);
  localparam logic [X_BITS:0]      ONE_X    = (X_BITS+1)'(1);
  localparam logic [Y_BITS:0]      ONE_Y    = (Y_BITS+1)'(1);

  state_t                state, state_nxt;
  logic [X_BITS:0]       col, col_nxt, w_r, w_nxt, w_eff;
  logic [Y_BITS:0]       row, row_nxt, h_r, h_nxt, h_eff;
  logic [ADDR_BITS-1:0]  row_base, row_base_nxt, wr_addr_nxt, start_addr;
  logic [DATA_WIDTH-1:0] wr_in_nxt;
  logic                  wr_en_nxt, done_nxt, busy_nxt;
  logic                  accept, last_col, last_row;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

`ifdef RECT_FILL_CLIP_EN
  localparam logic [X_BITS:0] SCREEN_W_X = (X_BITS+1)'(SCREEN_W);
  localparam logic [Y_BITS:0] SCREEN_H_Y = (Y_BITS+1)'(SCREEN_H);
  logic [X_BITS:0] w_room;
  logic [Y_BITS:0] h_room;

  // Room left to the screen edge; an origin off-screen collapses to an empty command.
  always_comb begin
    w_room = SCREEN_W_X - {1'b0, cmd_x};
    h_room = SCREEN_H_Y - {1'b0, cmd_y};
    w_eff  = (cmd_w < w_room) ? cmd_w : w_room;
    h_eff  = (cmd_h < h_room) ? cmd_h : h_room;
    if (({1'b0, cmd_x} >= SCREEN_W_X) || ({1'b0, cmd_y} >= SCREEN_H_Y)) begin
      w_eff = '0;
      h_eff = '0;
    end
  end
`else
  assign w_eff = cmd_w;
  assign h_eff = cmd_h;
`endif

  // The only multiply: row base of the first pixel, taken once at accept.
  assign start_addr = ADDR_BITS'(cmd_y) * ROW_STEP + ADDR_BITS'(cmd_x);
  assign last_col   = (col == w_r - ONE_X);
  assign last_row   = (row == h_r - ONE_Y);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    w_nxt        = w_r;
    h_nxt        = h_r;
    row_base_nxt = row_base;
    wr_addr_nxt  = wr_addr;
    wr_in_nxt    = wr_in;
    wr_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          w_nxt     = w_eff;
          h_nxt     = h_eff;
          wr_in_nxt = cmd_color;
          if ((w_eff == '0) || (h_eff == '0)) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt    = FILL;
            wr_en_nxt    = 1'b1;
            busy_nxt     = 1'b1;
            wr_addr_nxt  = start_addr;
            row_base_nxt = start_addr;
            col_nxt      = '0;
            row_nxt      = '0;
          end
        end
      end
      FILL: begin
        if (last_col && last_row) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          wr_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
          if (last_col) begin
            col_nxt      = '0;
            row_nxt      = row + ONE_Y;
            row_base_nxt = row_base + ROW_STEP;
            wr_addr_nxt  = row_base + ROW_STEP;
          end else begin
            col_nxt     = col + ONE_X;
            wr_addr_nxt = wr_addr + ADDR_BITS'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      w_r      <= '0;
      h_r      <= '0;
      row_base <= '0;
      wr_addr  <= '0;
      wr_in    <= '0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      w_r      <= w_nxt;
      h_r      <= h_nxt;
      row_base <= row_base_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_in    <= wr_in_nxt;
      wr_en    <= wr_en_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: reset, basic fill, empty, clip/no-clip edge,
// back-to-back commands and reset in the middle of a fill.
module tb_rect_fill;
  localparam int DW = 8;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int AB = $clog2(SW*SH);
  localparam int XB = $clog2(SW);
  localparam int YB = $clog2(SH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [XB-1:0] cmd_x = '0;
  logic [YB-1:0] cmd_y = '0;
  logic [XB:0]   cmd_w = '0;
  logic [YB:0]   cmd_h = '0;
  logic [DW-1:0] cmd_color = '0;
  logic          busy, done, wr_en;
  logic [AB-1:0] wr_addr;
  logic [DW-1:0] wr_in;

  always #5 clk = ~clk;

  rect_fill #(.DATA_WIDTH(DW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .wr_clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_in(wr_in)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int done_cyc[$];

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(int'(wr_in));
      wq_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cyc.delete();
  endtask

  // Presents a command and returns at the cycle after the accept edge (+1 time unit).
  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input bit hold);
    bit ok = 1'b0;
    bit rdy;
    @(negedge clk); #1;
    cmd_x = XB'(x); cmd_y = YB'(y); cmd_w = (XB+1)'(w); cmd_h = (YB+1)'(h);
    cmd_color = DW'(c); cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; break; end
    end
    @(negedge clk); #1;
    acc_cyc = cyc;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_x = '1; cmd_y = '1; cmd_w = '1; cmd_h = '1; cmd_color = '1;
    end
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL accept_timeout: accepted=%0b required=1", ok); end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    if (done === 1'b1) begin seen = 1'b1; return; end
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({wr_en, done, busy, cmd_ready} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_flags: wr_en/done/busy/ready=%b required=0000", {wr_en, done, busy, cmd_ready});
      end
      n_cmp++;
      if (wr_addr !== '0 || wr_in !== '0) begin
        n_bad++; $display("FAIL reset_addr_data: addr=%0d data=%0h required=0/0", wr_addr, wr_in);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: cmd_ready=%b required=1", cmd_ready); end
  endtask

  task automatic test_basic();
    bit seen;
    int exp_addr[6] = '{482, 483, 484, 642, 643, 644};
    clear_log();
    issue(2, 3, 3, 2, 'hA5, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: busy=%b required=1", busy); end
    wait_done(50, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL basic_done_timeout: done never seen"); end
    n_cmp++;
    if ({wr_en, busy, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL basic_done_flags: wr_en/busy/ready=%b required=001", {wr_en, busy, cmd_ready});
    end
    @(negedge clk); #1;
    n_cmp++;
    if (wq_addr.size() !== 6) begin
      n_bad++; $display("FAIL basic_count: writes=%0d required=6", wq_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== 'hA5 || wq_cyc[i] !== acc_cyc + i) begin
          n_bad++; $display("FAIL basic_pixel%0d: addr=%0d data=%0h cyc=%0d required %0d/a5/%0d",
                            i, wq_addr[i], wq_data[i], wq_cyc[i], exp_addr[i], acc_cyc + i);
        end
      end
      n_cmp++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== wq_cyc[5] + 1) begin
        n_bad++; $display("FAIL basic_done_pulse: pulses=%0d required one right after last write", done_cyc.size());
      end
    end
  endtask

  task automatic test_empty();
    clear_log();
    issue(5, 5, 0, 5, 'h33, 1'b0);
    n_cmp++;
    if ({done, wr_en, busy, cmd_ready} !== 4'b1001) begin
      n_bad++; $display("FAIL empty_flags: done/wr_en/busy/ready=%b required=1001", {done, wr_en, busy, cmd_ready});
    end
    @(negedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || wq_addr.size() !== 0) begin
      n_bad++; $display("FAIL empty_after: done=%b writes=%0d required 0/0", done, wq_addr.size());
    end
  endtask

`ifdef RECT_FILL_CLIP_EN
  task automatic test_clip();
    bit seen;
    clear_log();
    issue(158, 119, 4, 4, 'h3C, 1'b0);
    wait_done(50, seen);
    @(negedge clk); #1;
    n_cmp++;
    if (!seen || wq_addr.size() !== 2) begin
      n_bad++; $display("FAIL clip_count: done=%0b writes=%0d required 1/2", seen, wq_addr.size());
    end else begin
      n_cmp++;
      if (wq_addr[0] !== 19198 || wq_addr[1] !== 19199) begin
        n_bad++; $display("FAIL clip_addr: %0d,%0d required 19198,19199", wq_addr[0], wq_addr[1]);
      end
    end
    clear_log();
    issue(160, 0, 4, 4, 'h3C, 1'b0);
    n_cmp++;
    if (done !== 1'b1 || wr_en !== 1'b0) begin
      n_bad++; $display("FAIL clip_offscreen: done=%b wr_en=%b required 1/0", done, wr_en);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (wq_addr.size() !== 0) begin n_bad++; $display("FAIL clip_offscreen_writes: %0d required 0", wq_addr.size()); end
  endtask
`else
  task automatic test_no_clip();
    bit seen;
    clear_log();
    issue(158, 119, 4, 1, 'h3C, 1'b0);
    wait_done(50, seen);
    @(negedge clk); #1;
    n_cmp++;
    if (!seen || wq_addr.size() !== 4) begin
      n_bad++; $display("FAIL noclip_count: done=%0b writes=%0d required 1/4", seen, wq_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wq_addr[i] !== 19198 + i) begin
          n_bad++; $display("FAIL noclip_addr%0d: %0d required %0d", i, wq_addr[i], 19198 + i);
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit seen;
    int bad_seq = 0;
    clear_log();
    issue(0, 0, 160, 120, 'h11, 1'b1);
    cmd_x = '0; cmd_y = '0; cmd_w = 1; cmd_h = 1; cmd_color = 'h22;
    wait_done(20000, seen);
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL b2b_done_timeout: clear never completed"); end
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_in !== 8'h22) begin
      n_bad++; $display("FAIL b2b_second_start: wr_en=%b addr=%0d data=%0h required 1/0/22", wr_en, wr_addr, wr_in);
    end
    wait_done(50, seen);
    @(negedge clk); #1;
    n_cmp++;
    if (!seen || wq_addr.size() !== 19201 || done_cyc.size() !== 2) begin
      n_bad++; $display("FAIL b2b_count: done=%0b writes=%0d pulses=%0d required 1/19201/2",
                        seen, wq_addr.size(), done_cyc.size());
    end else begin
      for (int i = 0; i < 19200; i++)
        if (wq_addr[i] !== i || wq_data[i] !== 'h11 || wq_cyc[i] !== wq_cyc[0] + i) bad_seq++;
      n_cmp++;
      if (bad_seq !== 0) begin n_bad++; $display("FAIL b2b_clear_seq: bad_pixels=%0d required 0", bad_seq); end
      n_cmp++;
      if (wq_addr[19200] !== 0 || wq_cyc[19200] !== wq_cyc[19199] + 2) begin
        n_bad++; $display("FAIL b2b_gap: addr=%0d gap=%0d required 0/2", wq_addr[19200], wq_cyc[19200] - wq_cyc[19199]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_log();
    issue(10, 10, 4, 4, 'h77, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({wr_en, busy, done, cmd_ready} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_flags: wr_en/busy/done/ready=%b required=0000", {wr_en, busy, done, cmd_ready});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (wq_addr.size() !== 3 || done_cyc.size() !== 0 || wq_addr[2] !== 1612) begin
      n_bad++; $display("FAIL rstmid_writes: writes=%0d pulses=%0d required 3/0", wq_addr.size(), done_cyc.size());
    end
    clear_log();
    issue(0, 1, 2, 1, 'h99, 1'b0);
    wait_done(50, seen);
    @(negedge clk); #1;
    n_cmp++;
    if (!seen || wq_addr.size() !== 2 || done_cyc.size() !== 1) begin
      n_bad++; $display("FAIL rstmid_next_count: done=%0b writes=%0d required 1/2", seen, wq_addr.size());
    end else begin
      n_cmp++;
      if (wq_addr[0] !== 160 || wq_addr[1] !== 161 || wq_data[1] !== 'h99) begin
        n_bad++; $display("FAIL rstmid_next_addr: %0d,%0d data=%0h required 160,161/99", wq_addr[0], wq_addr[1], wq_data[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
`ifdef RECT_FILL_CLIP_EN
    test_clip();
`else
    test_no_clip();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
